fetch_stage: RTL

Pipelined instruction-fetch stage that drives the decode stage's `InstrD`/`PCPlus4D` inputs and consumes its `PCSrcD`/`PCBranchD` redirect. Owns the PC register and issues in-order requests to a variable-latency instruction memory. Buffers returned words in a small in-order queue and holds the F/D pipeline register. Honours the hazard unit's stall and discards wrong-path fetches on a taken branch or jump.

---
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, in-order fetch queue with drop tracking, and the F/D register.
// Define FETCH_BYPASS_EN to let a response land in F/D on its arrival edge when nothing is queued.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LIM_C  = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C = CW'(1'b0);
  localparam logic [AW-1:0] PONE_C = AW'(1'b1);
  localparam logic [AW-1:0] PZER_C = AW'(1'b0);

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];
  logic          r_run;
  logic [31:0]   r_instr_d;
  logic [31:0]   r_pc4_d;
  logic          r_valid_d;

  logic          w_redirect;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_discard;
  logic          w_keep;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outst_nxt;
  logic [CW-1:0] w_count_nxt;

  // Handshake decode; w_resp ignores stray responses when nothing is outstanding.
  always_comb begin
    w_redirect = PCSrcD && !StallF;
    w_occ      = {1'b0, r_outst} + {1'b0, r_count};
    w_req      = r_run && !w_redirect && (w_occ < LIM_C);
    w_accept   = w_req && imem_ready;
    w_resp     = imem_rvalid && (r_outst != ZERO_C);
    w_discard  = w_resp && (r_drop != ZERO_C);
    w_keep     = w_resp && (r_drop == ZERO_C) && !w_redirect;
`ifdef FETCH_BYPASS_EN
    w_bypass   = w_keep && (r_count == ZERO_C) && !StallF;
`else
    w_bypass   = 1'b0;
`endif
    w_push     = w_keep && !w_bypass;
    w_pop      = !StallF && !w_redirect && (r_count != ZERO_C);
  end

  // Next-value arithmetic for the outstanding and queue-occupancy counters.
  always_comb begin
    w_outst_nxt = r_outst;
    w_count_nxt = r_count;
    if (w_accept && !w_resp) begin
      w_outst_nxt = r_outst + ONE_C;
    end else if (!w_accept && w_resp) begin
      w_outst_nxt = r_outst - ONE_C;
    end else begin
      w_outst_nxt = r_outst;
    end
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + ONE_C;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - ONE_C;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // PC, response-PC tracker, outstanding/drop counters and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= ZERO_C;
      r_drop   <= ZERO_C;
      r_count  <= ZERO_C;
      r_head   <= PZER_C;
      r_tail   <= PZER_C;
    end else begin
      r_run   <= 1'b1;
      r_outst <= w_outst_nxt;
      if (w_redirect) begin
        // Everything still in flight is stale; a response landing now is already consumed.
        r_pc     <= PCBranchD;
        r_rsp_pc <= PCBranchD;
        r_drop   <= r_outst - (w_resp ? ONE_C : ZERO_C);
        r_count  <= ZERO_C;
        r_head   <= PZER_C;
        r_tail   <= PZER_C;
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        if (w_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_discard) r_drop <= r_drop - ONE_C;
        if (w_push) r_tail <= r_tail + PONE_C;
        if (w_pop) r_head <= r_head + PONE_C;
        r_count <= w_count_nxt;
      end
    end
  end

  // Queue storage: each entry carries the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_instr[i] <= 32'h0000_0000;
        r_q_pc[i]    <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc[r_tail]    <= r_rsp_pc;
    end
  end

  // F/D pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d <= NOP;
      r_pc4_d   <= 32'h0000_0000;
      r_valid_d <= 1'b0;
    end else if (w_redirect) begin
      r_instr_d <= NOP;
      r_valid_d <= 1'b0;
    end else if (StallF) begin
      r_instr_d <= r_instr_d;
      r_pc4_d   <= r_pc4_d;
      r_valid_d <= r_valid_d;
    end else if (r_count != ZERO_C) begin
      r_instr_d <= r_q_instr[r_head];
      r_pc4_d   <= r_q_pc[r_head] + 32'd4;
      r_valid_d <= 1'b1;
    end else if (w_bypass) begin
      r_instr_d <= imem_rdata;
      r_pc4_d   <= r_rsp_pc + 32'd4;
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= NOP;
      r_valid_d <= 1'b0;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign InstrD    = r_instr_d;
  assign PCPlus4D  = r_pc4_d;
  assign ValidD    = r_valid_d;

endmodule
